rect_swap_proposer: RTL and testbench

- Upstream stage of the checkerboard swapping unit in the rectangle-loop randomizer for binary matrices.
- Accepts a swap budget and the live matrix, then draws pseudo-random index quadruples (r1,c1,r2,c2) from an internal LFSR.
- Keeps only quadruples that form a valid checkerboard rectangle and hands each one downstream over a valid/ready handshake.
- Each accepted swap preserves row and column sums; this block guarantees that the downstream swapper only ever receives legal rectangles.

---
 rtl/rect_loop_pkg.sv | 27 ++
 rtl/rect_lfsr.sv | 25 ++
 rtl/rect_swap_proposer.sv | 171 +++++++++++++++++
 tb/tb_rect_swap_proposer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_loop_pkg.sv
// Shared types and constants for the rectangle-loop randomizer.
// The proposer and the downstream swapping stage both import this package.
package rect_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    CHECK,
    PROPOSE,
    FIN
  } state_t;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Index fields are sized for the largest supported matrix (256x256)
  localparam int IDX_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] r1;
    logic [IDX_W-1:0] c1;
    logic [IDX_W-1:0] r2;
    logic [IDX_W-1:0] c2;
  } rect_idx_t;

endpackage

// File: rtl/rect_lfsr.sv
// Galois LFSR with enable and configurable seed and feedback mask.
// Shifts right; the bit shifted out selects whether the mask is applied.
module rect_lfsr
  import rect_loop_pkg::*;
#(
  parameter int            W    = 16,
  parameter logic [W-1:0]  TAPS = W'(LFSR_TAPS),
  parameter logic [W-1:0]  SEED = W'(DEFAULT_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] value
);

  // Step the register only when enabled; reset reloads the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/rect_swap_proposer.sv
// Rectangle swap proposer: draws random index quadruples from an LFSR,
// keeps only legal checkerboard rectangles of the live matrix and hands
// them downstream over valid/ready until the swap budget is used up.
// Optional build macro RECT_PROP_STATS_EN adds a saturating reject_cnt.
module rect_swap_proposer
  import rect_loop_pkg::*;
#(
  parameter int                 ROW_LEN   = 4,
  parameter int                 COL_LEN   = 4,
  parameter int                 LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                 MAX_TRIES = 64,
  localparam int                RW        = $clog2(ROW_LEN),
  localparam int                CW        = $clog2(COL_LEN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [11:0]                num_swaps,
  input  logic [ROW_LEN*COL_LEN-1:0] mat_in,
  output logic                       prop_valid,
  input  logic                       prop_ready,
  output logic [RW-1:0]              r1,
  output logic [RW-1:0]              r2,
  output logic [CW-1:0]              c1,
  output logic [CW-1:0]              c2,
  output logic                       busy,
  output logic                       done,
  output logic                       err
`ifdef RECT_PROP_STATS_EN
  ,
  output logic [15:0]                reject_cnt
`endif
);

  localparam int              TW        = $clog2(MAX_TRIES + 1);
  localparam int              MIW       = $clog2(ROW_LEN * COL_LEN);
  localparam logic [TW-1:0]   TRY_LIMIT = TW'(MAX_TRIES);

  state_t            state;
  rect_idx_t         cand;
  logic [11:0]       rem;
  logic [TW-1:0]     tries;
  logic [LFSR_W-1:0] lfsr_q;

  logic [RW-1:0] f_r1, f_r2;
  logic [CW-1:0] f_c1, f_c2;
  logic          in_range;
  logic [MIW-1:0] i11, i12, i21, i22;
  logic          m11, m12, m21, m22;
  logic          rect_ok;
  logic          abort;

  rect_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS)),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .value (lfsr_q)
  );

  // Slice the current LFSR value into r1, c1, r2, c2 from the low end up
  assign f_r1 = RW'(lfsr_q);
  assign f_c1 = CW'(lfsr_q >> RW);
  assign f_r2 = RW'(lfsr_q >> (RW + CW));
  assign f_c2 = CW'(lfsr_q >> (2 * RW + CW));
  assign in_range = (int'(f_r1) < ROW_LEN) && (int'(f_r2) < ROW_LEN) &&
                    (int'(f_c1) < COL_LEN) && (int'(f_c2) < COL_LEN);

  // Corner lookups of the registered candidate in the row-major matrix
  assign i11 = MIW'(int'(cand.r1) * COL_LEN + int'(cand.c1));
  assign i12 = MIW'(int'(cand.r1) * COL_LEN + int'(cand.c2));
  assign i21 = MIW'(int'(cand.r2) * COL_LEN + int'(cand.c1));
  assign i22 = MIW'(int'(cand.r2) * COL_LEN + int'(cand.c2));
  assign m11 = mat_in[i11];
  assign m12 = mat_in[i12];
  assign m21 = mat_in[i21];
  assign m22 = mat_in[i22];

  assign rect_ok = (cand.r1 != cand.r2) && (cand.c1 != cand.c2) &&
                   (m11 != m12) && (m11 == m22) && (m12 == m21);
  assign abort   = (tries >= TRY_LIMIT);

  assign r1 = RW'(cand.r1);
  assign c1 = CW'(cand.c1);
  assign r2 = RW'(cand.r2);
  assign c2 = CW'(cand.c2);

  // Proposal FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      rem        <= '0;
      tries      <= '0;
      prop_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef RECT_PROP_STATS_EN
      reject_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= num_swaps;
            tries <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
`ifdef RECT_PROP_STATS_EN
            reject_cnt <= '0;
`endif
            state <= (num_swaps == 12'd0) ? FIN : DRAW;
          end
        end
        DRAW: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (!in_range) begin
            tries <= tries + 1'b1;
`ifdef RECT_PROP_STATS_EN
            if (reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
`endif
          end else begin
            cand.r1 <= IDX_W'(f_r1);
            cand.c1 <= IDX_W'(f_c1);
            cand.r2 <= IDX_W'(f_r2);
            cand.c2 <= IDX_W'(f_c2);
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (rect_ok) begin
            prop_valid <= 1'b1;
            state      <= PROPOSE;
          end else begin
            tries <= tries + 1'b1;
`ifdef RECT_PROP_STATS_EN
            if (reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
`endif
            state <= DRAW;
          end
        end
        PROPOSE: begin
          if (prop_ready) begin
            prop_valid <= 1'b0;
            rem        <= rem - 12'd1;
            tries      <= '0;
            state      <= (rem == 12'd1) ? FIN : DRAW;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_swap_proposer.sv
// Directed testbench for rect_swap_proposer on a 4x4 matrix.
module tb_rect_swap_proposer;

  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] num_swaps;
  logic [15:0] mat_in;
  logic        prop_valid;
  logic        prop_ready;
  logic [1:0]  r1, r2, c1, c2;
  logic        busy, done, err;
`ifdef RECT_PROP_STATS_EN
  logic [15:0] reject_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] model;
  logic [7:0]  props[$];
  logic [7:0]  ref_props[$];

  always #5 clk = ~clk;

  rect_swap_proposer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_swaps  (num_swaps),
    .mat_in     (mat_in),
    .prop_valid (prop_valid),
    .prop_ready (prop_ready),
    .r1         (r1),
    .r2         (r2),
    .c1         (c1),
    .c2         (c2),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef RECT_PROP_STATS_EN
    ,
    .reject_cnt (reject_cnt)
`endif
  );

  // Bound on total runtime in case the DUT wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic bit_at(input logic [15:0] m, input int r, input int c);
    logic [15:0] t;
    t = m >> (r * COLS + c);
    return t[0];
  endfunction

  function automatic logic rect_legal(input logic [15:0] m, input int a1, input int b1,
                                      input int a2, input int b2);
    logic m11, m12, m21, m22;
    m11 = bit_at(m, a1, b1);
    m12 = bit_at(m, a1, b2);
    m21 = bit_at(m, a2, b1);
    m22 = bit_at(m, a2, b2);
    return (a1 != a2) && (b1 != b2) && (m11 != m12) && (m11 == m22) && (m12 == m21);
  endfunction

  function automatic logic [15:0] apply_swap(input logic [15:0] m, input int a1, input int b1,
                                             input int a2, input int b2);
    logic [15:0] one;
    one = 16'h0001;
    return m ^ (one << (a1 * COLS + b1)) ^ (one << (a1 * COLS + b2)) ^
               (one << (a2 * COLS + b1)) ^ (one << (a2 * COLS + b2));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [11:0] n);
    num_swaps = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && busy; i++) tick();
    tick();
    tick();
  endtask

  // Acts as the downstream swapper: accepts proposals, applies them to the model
  task automatic run_session(input int max_cycles, output int hs, output int bad,
                             output logic saw_done, output logic saw_err, output logic saw_valid);
    int a1, b1, a2, b2;
    hs = 0; bad = 0; saw_done = 1'b0; saw_err = 1'b0; saw_valid = 1'b0;
    props.delete();
    for (int i = 0; i < max_cycles && !saw_done; i++) begin
      if (done) begin
        saw_done = 1'b1;
        saw_err  = err;
      end else if (prop_valid && prop_ready) begin
        saw_valid = 1'b1;
        a1 = int'(r1); b1 = int'(c1); a2 = int'(r2); b2 = int'(c2);
        if (!rect_legal(model, a1, b1, a2, b2)) bad++;
        props.push_back({r1, c1, r2, c2});
        hs++;
        model = apply_swap(model, a1, b1, a2, b2);
        tick();
        mat_in = model;
      end else begin
        if (prop_valid) saw_valid = 1'b1;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; prop_ready = 1'b0; num_swaps = '0; mat_in = '0;
    tick();
    tick();
    checks++; if (prop_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_prop_valid: got %b expected 0", prop_valid); end
    checks++; if ({r1, c1, r2, c2} !== 8'h00) begin failures++; $display("[TB] FAIL reset_indices: got %h expected 00", {r1, c1, r2, c2}); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, err}); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero_budget();
    model = 16'h8421; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd0);
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("[TB] FAIL zero_cycle1: got busy,done=%b expected 10", {busy, done}); end
    tick();
    checks++; if ({busy, done} !== 2'b01) begin failures++; $display("[TB] FAIL zero_cycle2: got busy,done=%b expected 01", {busy, done}); end
    checks++; if (prop_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_valid: got %b expected 0", prop_valid); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL zero_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_all_zero();
    int hs, bad;
    logic sd, se, sv;
    model = 16'h0000; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd5);
    run_session(400, hs, bad, sd, se, sv);
    checks++; if (sd !== 1'b1) begin failures++; $display("[TB] FAIL zeros_done: got %b expected 1", sd); end
    checks++; if (se !== 1'b1) begin failures++; $display("[TB] FAIL zeros_err: got %b expected 1", se); end
    checks++; if (sv !== 1'b0) begin failures++; $display("[TB] FAIL zeros_valid_seen: got %b expected 0", sv); end
    tick(); tick(); tick();
    checks++; if ({busy, err} !== 2'b01) begin failures++; $display("[TB] FAIL zeros_err_sticky: got busy,err=%b expected 01", {busy, err}); end
    pulse_start(12'd0);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL zeros_err_clear: got %b expected 0", err); end
    settle();
  endtask

  task automatic test_identity();
    int hs, bad;
    logic sd, se, sv;
    model = 16'h8421; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd8);
    run_session(3000, hs, bad, sd, se, sv);
    checks++; if (hs !== 8) begin failures++; $display("[TB] FAIL ident_handshakes: got %0d expected 8", hs); end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL ident_illegal: got %0d expected 0", bad); end
    checks++; if ({sd, se} !== 2'b10) begin failures++; $display("[TB] FAIL ident_done_err: got %b expected 10", {sd, se}); end
    settle();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    model = 16'h8421; mat_in = model; prop_ready = 1'b0;
    pulse_start(12'd1);
    for (int i = 0; i < 300 && !prop_valid; i++) tick();
    checks++; if (prop_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_valid: got %b expected 1", prop_valid); end
    held = {r1, c1, r2, c2};
    checks++; if (rect_legal(model, int'(r1), int'(c1), int'(r2), int'(c2)) !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_legal: got %h expected legal rectangle", held);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({prop_valid, r1, c1, r2, c2} !== {1'b1, held}) begin
        failures++; $display("[TB] FAIL bp_hold_%0d: got %h expected %h", i, {prop_valid, r1, c1, r2, c2}, {1'b1, held});
      end
    end
    prop_ready = 1'b1;
    tick();
    checks++; if (prop_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_accept: got %b expected 0", prop_valid); end
    model = apply_swap(model, int'(held[7:6]), int'(held[5:4]), int'(held[3:2]), int'(held[1:0]));
    mat_in = model;
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL bp_done: got %b expected 1", done); end
    settle();
  endtask

  task automatic test_reset_mid_propose();
    int hs, bad;
    logic sd, se, sv;
    apply_reset();
    model = 16'h8421; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd3);
    run_session(2000, hs, bad, sd, se, sv);
    ref_props = props;
    checks++; if (hs !== 3) begin failures++; $display("[TB] FAIL rst_ref_count: got %0d expected 3", hs); end
    settle();

    apply_reset();
    model = 16'h8421; mat_in = model; prop_ready = 1'b0;
    pulse_start(12'd3);
    for (int i = 0; i < 300 && !prop_valid; i++) tick();
    checks++; if ({prop_valid, r1, c1, r2, c2} !== {1'b1, ref_props[0]}) begin
      failures++; $display("[TB] FAIL rst_first_prop: got %h expected %h", {prop_valid, r1, c1, r2, c2}, {1'b1, ref_props[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({prop_valid, r1, c1, r2, c2, busy, done, err} !== 12'h000) begin
      failures++; $display("[TB] FAIL rst_async_clear: got %h expected 000", {prop_valid, r1, c1, r2, c2, busy, done, err});
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    model = 16'h8421; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd3);
    run_session(2000, hs, bad, sd, se, sv);
    checks++; if (hs !== 3) begin failures++; $display("[TB] FAIL rst_replay_count: got %0d expected 3", hs); end
    for (int i = 0; i < 3 && i < hs; i++) begin
      checks++; if (props[i] !== ref_props[i]) begin
        failures++; $display("[TB] FAIL rst_replay_%0d: got %h expected %h", i, props[i], ref_props[i]);
      end
    end
    settle();
  endtask

  task automatic test_start_while_busy();
    int hs, bad;
    logic sd, se, sv;
    model = 16'h8421; mat_in = model; prop_ready = 1'b1;
    pulse_start(12'd2);
    num_swaps = 12'd7;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    run_session(2000, hs, bad, sd, se, sv);
    checks++; if (hs !== 2) begin failures++; $display("[TB] FAIL busy_start_count: got %0d expected 2", hs); end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL busy_start_illegal: got %0d expected 0", bad); end
    checks++; if ({sd, se} !== 2'b10) begin failures++; $display("[TB] FAIL busy_start_done: got %b expected 10", {sd, se}); end
    settle();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_zero_budget();
    test_all_zero();
    test_identity();
    test_backpressure();
    test_reset_mid_propose();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
